// File: rtl/fwd_hazard_ctrl_if.sv
// Handshake bundle between the ID/EX control path and the hazard controller.
// The pipeline side drives ID fields and stall inputs; the controller drives selects.
interface fwd_hazard_ctrl_if;
  logic       id_valid;
  logic [4:0] id_rs1;
  logic [4:0] id_rs2;
  logic       id_rs1_used;
  logic       id_rs2_used;
  logic [4:0] id_rd;
  logic       id_regwrite;
  logic       id_memread;
  logic       ex_redirect;
  logic       mem_stall;
  logic       stall_if;
  logic       bubble_ex;
  logic       flush_id;
  logic [1:0] fwd_a_sel;
  logic [1:0] fwd_b_sel;

  modport master (
    output id_valid, id_rs1, id_rs2,
    output id_rs1_used, id_rs2_used,
    output id_rd, id_regwrite, id_memread,
    output ex_redirect, mem_stall,
    input  stall_if, bubble_ex, flush_id,
    input  fwd_a_sel, fwd_b_sel
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2,
    input  id_rs1_used, id_rs2_used,
    input  id_rd, id_regwrite, id_memread,
    input  ex_redirect, mem_stall,
    output stall_if, bubble_ex, flush_id,
    output fwd_a_sel, fwd_b_sel
  );
endinterface

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding select and load-use / redirect hazard control for the 5-stage core.
// Define HAZ_FORWARD_EN to enable operand forwarding; otherwise it stalls on RAW.
module fwd_hazard_ctrl (
  input logic          clk,
  input logic          rst,
  fwd_hazard_ctrl_if.slave bus
);

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       regwrite;
    logic       memread;
  } ent_t;

  ent_t ex_q;
  ent_t mem_q;
  ent_t wb_q;

  logic ex_a;
  logic ex_b;
  logic mem_a;
  logic mem_b;
  logic hazard;
  logic stall;
  logic bubble;
  logic flush;
  logic take;
  logic unused_bits;

  function automatic logic hit(
    input ent_t       e,
    input logic [4:0] rs,
    input logic       used
  );
    return e.valid & e.regwrite
         & (e.rd != 5'd0)
         & (e.rd == rs) & used;
  endfunction

  assign ex_a  = hit(ex_q, bus.id_rs1, bus.id_rs1_used);
  assign ex_b  = hit(ex_q, bus.id_rs2, bus.id_rs2_used);
  assign mem_a = hit(mem_q, bus.id_rs1, bus.id_rs1_used);
  assign mem_b = hit(mem_q, bus.id_rs2, bus.id_rs2_used);

`ifdef HAZ_FORWARD_EN
  // Only a load still in EX cannot be forwarded in time.
  assign hazard = bus.id_valid & ex_q.memread
                & (ex_a | ex_b);
`else
  // Without forwarding, any in-flight producer blocks the consumer.
  assign hazard = bus.id_valid
                & (ex_a | ex_b | mem_a | mem_b);
`endif

  // Prioritised stall / bubble / flush; reset forces all low at once.
  always_comb begin
    stall  = 1'b0;
    bubble = 1'b0;
    flush  = 1'b0;
    if (rst) begin
      stall = 1'b0;
    end else if (bus.mem_stall) begin
      stall = 1'b1;
    end else if (bus.ex_redirect) begin
      flush  = 1'b1;
      bubble = 1'b1;
    end else if (hazard) begin
      stall  = 1'b1;
      bubble = 1'b1;
    end
  end

  assign bus.stall_if  = stall;
  assign bus.bubble_ex = bubble;
  assign bus.flush_id  = flush;

  assign take = ~bus.mem_stall & bus.id_valid & ~bubble;

  // Shadow destination state advances with the datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else if (!bus.mem_stall) begin
      wb_q  <= mem_q;
      mem_q <= ex_q;
      if (take) begin
        ex_q <= '{valid:    1'b1,
                  rd:       bus.id_rd,
                  regwrite: bus.id_regwrite,
                  memread:  bus.id_memread};
      end else begin
        ex_q <= '0;
      end
    end
  end

`ifdef HAZ_FORWARD_EN
  logic [1:0] a_nxt;
  logic [1:0] b_nxt;
  logic [1:0] a_q;
  logic [1:0] b_q;

  // Newest producer wins: EX (soon MEM) beats MEM (soon WB).
  always_comb begin
    a_nxt = 2'b00;
    b_nxt = 2'b00;
    if (ex_a)       a_nxt = 2'b01;
    else if (mem_a) a_nxt = 2'b10;
    if (ex_b)       b_nxt = 2'b01;
    else if (mem_b) b_nxt = 2'b10;
  end

  // Selects follow the instruction into EX; bubbles get 00.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q <= 2'b00;
      b_q <= 2'b00;
    end else if (!bus.mem_stall) begin
      a_q <= take ? a_nxt : 2'b00;
      b_q <= take ? b_nxt : 2'b00;
    end
  end

  assign bus.fwd_a_sel = a_q;
  assign bus.fwd_b_sel = b_q;
`else
  assign bus.fwd_a_sel = 2'b00;
  assign bus.fwd_b_sel = 2'b00;
`endif

  // WB entry and memread bits are kept for visibility only.
  assign unused_bits = ^{wb_q, mem_q.memread, ex_q.memread};

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Randomised scoreboard bench for fwd_hazard_ctrl.
// Model tracks in-flight producers by distance from ID.
module tb_fwd_hazard_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fwd_hazard_ctrl_if bus ();

  fwd_hazard_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic       rst;
    logic       valid;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic [4:0] rd;
    logic       wr;
    logic       ld;
    logic       redir;
    logic       mstall;
  } stim_t;

  typedef struct {
    bit v;
    int rd;
    bit wr;
    bit ld;
  } prod_t;

  typedef struct {
    logic       stall;
    logic       bubble;
    logic       flush;
    logic [1:0] a;
    logic [1:0] b;
  } exp_t;

  exp_t  sb[$];
  prod_t hist[$];
  logic [1:0] m_a = 2'b00;
  logic [1:0] m_b = 2'b00;
  int n_tests = 0;
  int n_fail  = 0;

  function automatic bit writes(prod_t p, int rs, bit used);
    return p.v && p.wr && p.rd != 0 && p.rd == rs && used;
  endfunction

  function automatic logic [1:0] pick(int rs, bit used);
`ifdef HAZ_FORWARD_EN
    for (int d = 0; d < hist.size(); d++)
      if (writes(hist[d], rs, used))
        return (d == 0) ? 2'b01 : 2'b10;
`endif
    return 2'b00;
  endfunction

  function automatic bit dep(int d, stim_t s);
    if (d >= hist.size()) return 0;
    return writes(hist[d], s.rs1, s.u1) ||
           writes(hist[d], s.rs2, s.u2);
  endfunction

  function automatic stim_t mk(int rd, int r1, int r2,
                               bit u1, bit u2, bit wr, bit ld);
    stim_t s;
    s = '0;
    s.valid = 1'b1;
    s.rd = rd[4:0];
    s.rs1 = r1[4:0];
    s.rs2 = r2[4:0];
    s.u1 = u1;
    s.u2 = u2;
    s.wr = wr;
    s.ld = ld;
    return s;
  endfunction

  task automatic step(input stim_t s);
    exp_t  e;
    bit    haz;
    bit    take;
    prod_t n;
    logic [1:0] na;
    logic [1:0] nb;
    @(posedge clk);
    #1;
    bus.id_valid    = s.valid;
    bus.id_rs1      = s.rs1;
    bus.id_rs2      = s.rs2;
    bus.id_rs1_used = s.u1;
    bus.id_rs2_used = s.u2;
    bus.id_rd       = s.rd;
    bus.id_regwrite = s.wr;
    bus.id_memread  = s.ld;
    bus.ex_redirect = s.redir;
    bus.mem_stall   = s.mstall;
    rst             = s.rst;
    e = '{1'b0, 1'b0, 1'b0, 2'b00, 2'b00};
    if (s.rst) begin
      hist.delete();
      m_a = 2'b00;
      m_b = 2'b00;
      sb.push_back(e);
      return;
    end
`ifdef HAZ_FORWARD_EN
    haz = s.valid && hist.size() > 0 &&
          hist[0].ld && dep(0, s);
`else
    haz = s.valid && (dep(0, s) || dep(1, s));
`endif
    e.a = m_a;
    e.b = m_b;
    if (s.mstall) begin
      e.stall = 1'b1;
    end else if (s.redir) begin
      e.flush = 1'b1;
      e.bubble = 1'b1;
    end else if (haz) begin
      e.stall = 1'b1;
      e.bubble = 1'b1;
    end
    sb.push_back(e);
    if (!s.mstall) begin
      take = s.valid && !e.bubble;
      na = take ? pick(s.rs1, s.u1) : 2'b00;
      nb = take ? pick(s.rs2, s.u2) : 2'b00;
      n.v = take;
      n.rd = s.rd;
      n.wr = s.wr;
      n.ld = s.ld;
      hist.push_front(n);
      if (hist.size() > 2) void'(hist.pop_back());
      m_a = na;
      m_b = nb;
    end
  endtask

  task automatic chk(string nm, logic [1:0] got, logic [1:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s t=%0t got=%b exp=%b", nm, $time, got, want);
    end
  endtask

  // Monitor: compare DUT outputs mid-cycle against queued expectations.
  always @(negedge clk) begin
    exp_t e;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk("stall_if",  {1'b0, bus.stall_if},  {1'b0, e.stall});
      chk("bubble_ex", {1'b0, bus.bubble_ex}, {1'b0, e.bubble});
      chk("flush_id",  {1'b0, bus.flush_id},  {1'b0, e.flush});
      chk("fwd_a_sel", bus.fwd_a_sel, e.a);
      chk("fwd_b_sel", bus.fwd_b_sel, e.b);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog t=%0t got=timeout exp=finish", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    stim_t s;
    stim_t nop;
    nop = '0;
    bus.id_valid = 0; bus.id_rs1 = 0; bus.id_rs2 = 0;
    bus.id_rs1_used = 0; bus.id_rs2_used = 0;
    bus.id_rd = 0; bus.id_regwrite = 0; bus.id_memread = 0;
    bus.ex_redirect = 0; bus.mem_stall = 0;
    s = '0;
    s.rst = 1'b1;
    step(s);
    step(s);
    repeat (2) step(nop);
    // add x5 ; sub x6,x5,x3
    step(mk(5, 1, 2, 1, 1, 1, 0));
    step(mk(6, 5, 3, 1, 1, 1, 0));
    repeat (3) step(nop);
    // add x5 ; nop ; or x7,x5,x5
    step(mk(5, 1, 2, 1, 1, 1, 0));
    step(nop);
    step(mk(7, 5, 5, 1, 1, 1, 0));
    repeat (3) step(nop);
    // lw x8 ; add x9,x8,x2 (held while stalled)
    step(mk(8, 1, 0, 1, 0, 1, 1));
    step(mk(9, 8, 2, 1, 1, 1, 0));
    step(mk(9, 8, 2, 1, 1, 1, 0));
    step(mk(9, 8, 2, 1, 1, 1, 0));
    repeat (3) step(nop);
    // addi x0 ; add x4,x0,x0
    step(mk(0, 0, 0, 1, 0, 1, 0));
    step(mk(4, 0, 0, 1, 1, 1, 0));
    repeat (3) step(nop);
    // lw x8 ; consumer redirected
    step(mk(8, 1, 0, 1, 0, 1, 1));
    s = mk(9, 8, 2, 1, 1, 1, 0);
    s.redir = 1'b1;
    step(s);
    step(nop);
    repeat (2) step(nop);
    // mem_stall for 3 cycles mid-dependency
    step(mk(5, 1, 2, 1, 1, 1, 0));
    s = mk(6, 5, 5, 1, 1, 1, 0);
    s.mstall = 1'b1;
    repeat (3) step(s);
    s.mstall = 1'b0;
    step(s);
    step(s);
    step(s);
    repeat (2) step(nop);
    // rst pulse during a stall
    step(mk(5, 1, 2, 1, 1, 1, 0));
    s = mk(6, 5, 5, 1, 1, 1, 0);
    s.mstall = 1'b1;
    step(s);
    s.rst = 1'b1;
    step(s);
    s.rst = 1'b0;
    s.mstall = 1'b0;
    step(s);
    repeat (2) step(nop);
    // Random traffic over a small register window
    for (int i = 0; i < 3000; i++) begin
      s = '0;
      s.rst    = ($urandom_range(0, 99) < 2);
      s.valid  = ($urandom_range(0, 9) < 8);
      s.rs1    = 5'($urandom_range(0, 3));
      s.rs2    = 5'($urandom_range(0, 3));
      s.u1     = $urandom_range(0, 1);
      s.u2     = $urandom_range(0, 1);
      s.rd     = 5'($urandom_range(0, 3));
      s.wr     = ($urandom_range(0, 3) != 0);
      s.ld     = ($urandom_range(0, 2) == 0);
      s.redir  = ($urandom_range(0, 9) == 0);
      s.mstall = ($urandom_range(0, 6) == 0);
      step(s);
    end
    step(nop);
    repeat (2) @(negedge clk);
    #1;
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain got=%0d exp=0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fwd_hazard_ctrl.md
# fwd_hazard_ctrl

Pipeline hazard controller for the 5-stage core. It keeps a shadow copy of the destination-register state for the EX, MEM and WB stages, and advances that copy in step with the datapath pipeline registers. From it the block generates the registered select codes for the EX-stage operand 3-input muxes, plus the load-use stall, bubble and flush controls. It sits beside the ID/EX pipeline register and is the only driver of the forwarding select lines.

## Interface
- No parameters.
- clk  in  1  core clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- id_valid  in  1  ID holds a real instruction.
- id_rs1, id_rs2  in  5  source register numbers of the ID instruction.
- id_rs1_used, id_rs2_used  in  1  ID instruction actually reads rs1 / rs2.
- id_rd  in  5  destination of the ID instruction.
- id_regwrite  in  1  ID instruction writes rd.
- id_memread  in  1  ID instruction is a load.
- ex_redirect  in  1  taken branch/jump resolved in EX this cycle.
- mem_stall  in  1  data memory not ready; whole pipeline frozen.
- stall_if  out  1  hold PC and IF/ID.
- bubble_ex  out  1  load a NOP into ID/EX.
- flush_id  out  1  clear IF/ID.
- fwd_a_sel, fwd_b_sel  out  2  EX operand select.
  - 2'b00: ID/EX register value.
  - 2'b01: EX/MEM ALU result.
  - 2'b10: MEM/WB writeback value.
  - 2'b11: never driven.

## Operation
- Shadow state: three entries (ex, mem, wb). Each entry holds {valid, rd, regwrite, memread}.
- A producer entry "matches" a source register when all of the following hold:
  - the entry is valid and has regwrite=1;
  - its rd is not 0;
  - its rd equals the source register;
  - the matching id_rsN_used bit is 1.
- Register x0 never matches.
- load_use: the ex entry is a load and matches rs1 or rs2 of a valid ID instruction.
- Control priority, evaluated combinationally each cycle:
  - mem_stall=1: stall_if=1, bubble_ex=0, flush_id=0. No shadow or select register changes.
  - else ex_redirect=1: flush_id=1, bubble_ex=1, stall_if=0. ex_redirect overrides load_use.
  - else load_use=1: stall_if=1, bubble_ex=1, flush_id=0.
  - else all three are 0.
- Shadow advance on each edge when mem_stall=0:
  - wb gets mem.
  - mem gets ex.
  - ex gets the ID fields if id_valid=1 and bubble_ex=0. Otherwise ex is cleared (valid=0).
- Forward select computation, per operand, from the pre-edge shadow state:
  - a match on the ex entry (it becomes MEM next cycle) gives 01;
  - otherwise a match on the mem entry (it becomes WB) gives 10;
  - otherwise 00.
  - The newest producer wins.
- fwd_*_sel loading:
  - the computed value is loaded when ex takes an ID instruction;
  - 00 is loaded when ex takes a bubble;
  - the registers hold during mem_stall.
- WB-to-ID hazards are not handled here: the register file is write-through.

## Timing
- Reset values: all shadow entries invalid, fwd_a_sel=fwd_b_sel=00, so stall_if=bubble_ex=flush_id=0.
- Reset asserted mid-stall clears all state immediately. Outputs drop to their reset values in the same cycle.
- stall_if, bubble_ex and flush_id are combinational: same-cycle from inputs and shadow state.
- fwd_*_sel are registered, with 1-cycle latency. They are valid for the whole cycle the consuming instruction occupies EX.
- A load-use stall lasts exactly 1 cycle (with forwarding compiled in). After it, the load is in MEM and the consumer gets 10.
- An ID instruction that is simultaneously load-use stalled and redirected is squashed, not stalled.

## Configuration
- HAZ_FORWARD_EN defined: behaviour as above.
- HAZ_FORWARD_EN undefined:
  - fwd_*_sel are tied to 00;
  - stall_if=bubble_ex=1 whenever the ID instruction matches the ex or mem entry, regardless of memread;
  - a dependency on the immediately preceding instruction stalls 2 cycles, and one two back stalls 1 cycle;
  - priority order is unchanged.

## Test plan
- add x5,x1,x2 then sub x6,x5,x3: the sub's EX cycle sees fwd_a_sel=01 and fwd_b_sel=00, with no stall.
- add x5; nop; or x7,x5,x5: the or's EX cycle sees fwd_a_sel=fwd_b_sel=10.
- lw x8,0(x1) then add x9,x8,x2: stall_if=bubble_ex=1 for 1 cycle, then fwd_a_sel=10 in the add's EX cycle.
- addi x0,x0,1 then add x4,x0,x0: both selects 00 and no stall (x0 never forwards).
- lw x8 followed by a consumer with ex_redirect=1 in the same cycle: flush_id=1 and bubble_ex=1, stall_if=0. The next EX shows selects 00.
- mem_stall held for 3 cycles mid-dependency: shadow state and selects are frozen and stall_if=1 throughout. Forwarding resumes correctly afterwards. rst pulsed during the stall makes all outputs 0 immediately.
